baw_turn_sequencer: RTL and testbench

- Game controller for the two-player black-and-white card game.
- Owns both 9-card hands, enforces turn order, validates plays, resolves each round and tracks round/win/lose counts and game end.
- Sits between the button/switch front end (play requests) and the display logic (7-seg/LED renderer).
- Replaces ad-hoc per-state card bookkeeping with one sequenced datapath.

---
 rtl/baw_turn_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_baw_turn_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baw_turn_sequencer.sv
// Turn sequencer for the two-player black-and-white card game: hands, turn order, round scoring, game end.
// Optional turn timeout auto-play is enabled with `define BAW_TURN_TIMEOUT_EN.
module baw_turn_sequencer #(
    parameter int WIN_TARGET     = 5,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       play_valid,
    input  logic       play_player,
    input  logic [8:0] play_sel,
    input  logic       next_round,
    output logic       play_ready,
    output logic       play_err,
    output logic       turn,
    output logic [8:0] p1_hand,
    output logic [8:0] p2_hand,
    output logic [3:0] p1_card,
    output logic [3:0] p2_card,
    output logic       lead_black,
    output logic [3:0] round,
    output logic [3:0] win,
    output logic [3:0] lose,
    output logic [1:0] match_result,
    output logic [1:0] game_result,
    output logic       game_over,
`ifdef BAW_TURN_TIMEOUT_EN
    output logic       timeout_fired,
`endif
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        LEAD    = 3'b001,
        FOLLOW  = 3'b010,
        RESOLVE = 3'b011,
        SHOW    = 3'b100,
        DONE    = 3'b101
    } state_t;

    localparam logic [3:0] WIN_T = 4'(WIN_TARGET);

    if (WIN_TARGET < 1 || WIN_TARGET > 9 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("baw_turn_sequencer: WIN_TARGET must be 1..9 and TIMEOUT_CYCLES >= 1");
    end

    state_t     state;
    logic       leader;
    logic [8:0] cur_hand;
    logic       one_hot;
    logic       req_ok;
    logic       req_bad;
    logic       tmo_hit;
    logic       take;
    logic [8:0] take_sel;
    logic [3:0] take_idx;
    logic       finished;

`ifdef BAW_TURN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    function automatic logic [3:0] card_index(input logic [8:0] sel);
        card_index = 4'd0;
        for (int i = 0; i < 9; i++)
            if (sel[i]) card_index = 4'(i);
    endfunction

    assign play_ready = (state == LEAD) || (state == FOLLOW);
    assign game_over  = (state == DONE);
    assign state_o    = state;

    always_comb begin
        cur_hand = turn ? p2_hand : p1_hand;
        one_hot  = (play_sel != 9'd0) && ((play_sel & (play_sel - 9'd1)) == 9'd0);
        req_ok   = play_valid && play_ready && (play_player == turn) && one_hot
                   && ((play_sel & cur_hand) == play_sel);
        req_bad  = play_valid && play_ready && !req_ok;
`ifdef BAW_TURN_TIMEOUT_EN
        tmo_hit  = play_ready && !req_ok && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
        tmo_hit  = 1'b0;
`endif
        take     = req_ok || tmo_hit;
        // Timeout auto-play picks the lowest-index card still held.
        take_sel = req_ok ? play_sel : (cur_hand & (~cur_hand + 9'd1));
        take_idx = card_index(take_sel);
        finished = (win == WIN_T) || (lose == WIN_T) || (round == 4'd9);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            leader       <= 1'b0;
            turn         <= 1'b0;
            p1_hand      <= 9'h1FF;
            p2_hand      <= 9'h1FF;
            p1_card      <= 4'd0;
            p2_card      <= 4'd0;
            lead_black   <= 1'b0;
            round        <= 4'd0;
            win          <= 4'd0;
            lose         <= 4'd0;
            match_result <= 2'b00;
            game_result  <= 2'b00;
            play_err     <= 1'b0;
`ifdef BAW_TURN_TIMEOUT_EN
            tmo_cnt       <= '0;
            timeout_fired <= 1'b0;
`endif
        end else if (abort) begin
            state        <= IDLE;
            leader       <= 1'b0;
            turn         <= 1'b0;
            p1_hand      <= 9'h1FF;
            p2_hand      <= 9'h1FF;
            p1_card      <= 4'd0;
            p2_card      <= 4'd0;
            lead_black   <= 1'b0;
            round        <= 4'd0;
            win          <= 4'd0;
            lose         <= 4'd0;
            match_result <= 2'b00;
            game_result  <= 2'b00;
            play_err     <= 1'b0;
`ifdef BAW_TURN_TIMEOUT_EN
            tmo_cnt       <= '0;
            timeout_fired <= 1'b0;
`endif
        end else begin
            play_err <= req_bad;
`ifdef BAW_TURN_TIMEOUT_EN
            timeout_fired <= tmo_hit;
            if (play_ready && !take) tmo_cnt <= tmo_cnt + 1'b1;
            else                     tmo_cnt <= '0;
`endif
            if (take) begin
                if (turn) begin
                    p2_hand <= p2_hand & ~take_sel;
                    p2_card <= take_idx;
                end else begin
                    p1_hand <= p1_hand & ~take_sel;
                    p1_card <= take_idx;
                end
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LEAD;
                        leader       <= 1'b0;
                        turn         <= 1'b0;
                        p1_hand      <= 9'h1FF;
                        p2_hand      <= 9'h1FF;
                        p1_card      <= 4'd0;
                        p2_card      <= 4'd0;
                        lead_black   <= 1'b0;
                        round        <= 4'd0;
                        win          <= 4'd0;
                        lose         <= 4'd0;
                        match_result <= 2'b00;
                        game_result  <= 2'b00;
                    end
                end
                LEAD: begin
                    if (take) begin
                        state      <= FOLLOW;
                        leader     <= turn;
                        lead_black <= take_idx[0];
                        turn       <= ~turn;
                    end
                end
                FOLLOW: begin
                    if (take) state <= RESOLVE;
                end
                RESOLVE: begin
                    round <= round + 4'd1;
                    state <= SHOW;
                    if (p1_card > p2_card) begin
                        win          <= win + 4'd1;
                        match_result <= 2'b01;
                        turn         <= 1'b0;
                    end else if (p2_card > p1_card) begin
                        lose         <= lose + 4'd1;
                        match_result <= 2'b10;
                        turn         <= 1'b1;
                    end else begin
                        match_result <= 2'b11;
                        turn         <= leader;
                    end
                end
                SHOW: begin
                    if (next_round) begin
                        if (finished) begin
                            state <= DONE;
                            if (win > lose)      game_result <= 2'b01;
                            else if (lose > win) game_result <= 2'b10;
                            else                 game_result <= 2'b11;
                        end else begin
                            state <= LEAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_baw_turn_sequencer.sv
// Self-checking bench for baw_turn_sequencer: round scoreboard, rejection, draw, early win, full game, resets.
module tb_baw_turn_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, abort, play_valid, play_player, next_round;
    logic [8:0] play_sel;
    logic       play_ready, play_err, turn, lead_black, game_over;
    logic [8:0] p1_hand, p2_hand;
    logic [3:0] p1_card, p2_card, round, win, lose;
    logic [1:0] match_result, game_result;
    logic [2:0] state_o;
`ifdef BAW_TURN_TIMEOUT_EN
    logic       timeout_fired;
`endif

    baw_turn_sequencer #(.WIN_TARGET(5), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .play_valid(play_valid), .play_player(play_player), .play_sel(play_sel),
        .next_round(next_round), .play_ready(play_ready), .play_err(play_err),
        .turn(turn), .p1_hand(p1_hand), .p2_hand(p2_hand),
        .p1_card(p1_card), .p2_card(p2_card), .lead_black(lead_black),
        .round(round), .win(win), .lose(lose), .match_result(match_result),
        .game_result(game_result), .game_over(game_over),
`ifdef BAW_TURN_TIMEOUT_EN
        .timeout_fired(timeout_fired),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mr;
        logic [3:0] rnd;
        logic [3:0] w;
        logic [3:0] l;
        logic       nt;
        logic [8:0] h1;
        logic [8:0] h2;
        logic [3:0] c1;
        logic [3:0] c2;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [8:0] m_h1, m_h2;
    logic [3:0] m_rnd, m_w, m_l;
    logic       m_lead;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_new;
        m_h1 = 9'h1FF; m_h2 = 9'h1FF;
        m_rnd = 4'd0; m_w = 4'd0; m_l = 4'd0;
        m_lead = 1'b0;
    endtask

    task automatic drive_play(input logic p, input logic [8:0] sel);
        play_valid = 1'b1; play_player = p; play_sel = sel;
        tick;
        play_valid = 1'b0; play_sel = 9'd0;
    endtask

    task automatic new_game;
        start = 1'b1;
        tick;
        start = 1'b0;
        model_new;
    endtask

    // One full round through the scoreboard: leader plays, follower plays, SHOW compared, next_round.
    task automatic play_round(input int c1, input int c2);
        logic [8:0] s1, s2;
        logic       lb, fin;
        logic [2:0] exp_state;
        logic [1:0] exp_gr;
        exp_t       e;
        exp_t       got;
        int         n;
        s1 = 9'h001 << c1;
        s2 = 9'h001 << c2;
        e.c1 = 4'(c1); e.c2 = 4'(c2);
        lb = m_lead ? s2[1] | s2[3] | s2[5] | s2[7] : s1[1] | s1[3] | s1[5] | s1[7];
        m_h1 = m_h1 & ~s1;
        m_h2 = m_h2 & ~s2;
        m_rnd = m_rnd + 4'd1;
        if (c1 > c2) begin
            m_w = m_w + 4'd1; e.mr = 2'b01; m_lead = 1'b0;
        end else if (c2 > c1) begin
            m_l = m_l + 4'd1; e.mr = 2'b10; m_lead = 1'b1;
        end else begin
            e.mr = 2'b11;
        end
        e.rnd = m_rnd; e.w = m_w; e.l = m_l; e.nt = m_lead; e.h1 = m_h1; e.h2 = m_h2;
        sb.push_back(e);

        if (s1 == 9'h0 || s2 == 9'h0) $fatal(1, "bad card index");
        if (lb === 1'bx) $fatal(1, "bad lead bit");
        if (e.nt === 1'bx) $fatal(1, "bad leader");
        // Leader is whoever the model says led before this round's update.
        if ((c1 > c2 && m_lead == 1'b0) || (c2 > c1 && m_lead == 1'b1) || (c1 == c2)) begin end
        n = 0;
        if (turn == 1'b0) begin
            drive_play(1'b0, s1);
            lb = s1[1] | s1[3] | s1[5] | s1[7];
            checks++;
            if (state_o !== 3'b010 || lead_black !== lb) begin
                errors++;
                $display("FAIL lead_follow: state=%b lead_black=%b, want state=010 lead_black=%b", state_o, lead_black, lb);
            end
            drive_play(1'b1, s2);
        end else begin
            drive_play(1'b1, s2);
            lb = s2[1] | s2[3] | s2[5] | s2[7];
            checks++;
            if (state_o !== 3'b010 || lead_black !== lb) begin
                errors++;
                $display("FAIL lead_follow: state=%b lead_black=%b, want state=010 lead_black=%b", state_o, lead_black, lb);
            end
            drive_play(1'b0, s1);
        end

        while (state_o !== 3'b100 && n < 5) begin
            tick;
            n++;
        end
        checks++;
        if (state_o !== 3'b100) begin
            errors++;
            $display("FAIL reach_show: state=%b after %0d cycles, want 100", state_o, n);
        end
        got = sb.pop_front();
        checks++;
        if (match_result !== got.mr) begin
            errors++; $display("FAIL match_result: got %b want %b", match_result, got.mr);
        end
        checks++;
        if (round !== got.rnd || win !== got.w || lose !== got.l) begin
            errors++;
            $display("FAIL score: round=%0d win=%0d lose=%0d want %0d/%0d/%0d", round, win, lose, got.rnd, got.w, got.l);
        end
        checks++;
        if (p1_hand !== got.h1 || p2_hand !== got.h2) begin
            errors++; $display("FAIL hands: %h/%h want %h/%h", p1_hand, p2_hand, got.h1, got.h2);
        end
        checks++;
        if (p1_card !== got.c1 || p2_card !== got.c2) begin
            errors++; $display("FAIL cards: %0d/%0d want %0d/%0d", p1_card, p2_card, got.c1, got.c2);
        end
        checks++;
        if (turn !== got.nt) begin
            errors++; $display("FAIL next_leader: turn=%b want %b", turn, got.nt);
        end

        fin = (m_w == 4'd5) || (m_l == 4'd5) || (m_rnd == 4'd9);
        exp_state = fin ? 3'b101 : 3'b001;
        exp_gr = (m_w > m_l) ? 2'b01 : (m_l > m_w) ? 2'b10 : 2'b11;
        next_round = 1'b1;
        tick;
        next_round = 1'b0;
        checks++;
        if (state_o !== exp_state || game_over !== fin) begin
            errors++;
            $display("FAIL after_next: state=%b game_over=%b want %b/%b", state_o, game_over, exp_state, fin);
        end
        if (fin) begin
            checks++;
            if (game_result !== exp_gr) begin
                errors++; $display("FAIL game_result: got %b want %b", game_result, exp_gr);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; abort = 1'b0; play_valid = 1'b0;
        play_player = 1'b0; play_sel = 9'd0; next_round = 1'b0;
        tick; tick;
        reset = 1'b0;
        tick;
        checks++;
        if (state_o !== 3'b000 || p1_hand !== 9'h1FF || p2_hand !== 9'h1FF || round !== 4'd0
            || win !== 4'd0 || lose !== 4'd0 || match_result !== 2'b00 || game_result !== 2'b00
            || turn !== 1'b0 || play_ready !== 1'b0 || play_err !== 1'b0 || game_over !== 1'b0
            || p1_card !== 4'd0 || p2_card !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: state=%b hands=%h/%h round=%0d ready=%b err=%b over=%b", state_o,
                     p1_hand, p2_hand, round, play_ready, play_err, game_over);
        end
        drive_play(1'b0, 9'h001);
        checks++;
        if (play_err !== 1'b0 || state_o !== 3'b000 || p1_hand !== 9'h1FF) begin
            errors++; $display("FAIL idle_play: err=%b state=%b hand=%h want 0/000/1ff", play_err, state_o, p1_hand);
        end
    endtask

    task automatic test_basic_round;
        new_game;
        checks++;
        if (state_o !== 3'b001 || play_ready !== 1'b1) begin
            errors++; $display("FAIL start: state=%b ready=%b want 001/1", state_o, play_ready);
        end
        play_round(4, 2);
        checks++;
        if (round !== 4'd1 || win !== 4'd1 || turn !== 1'b0 || p1_hand !== 9'h1EF || p2_hand !== 9'h1FB) begin
            errors++;
            $display("FAIL basic_round: round=%0d win=%0d turn=%b hands=%h/%h", round, win, turn, p1_hand, p2_hand);
        end
    endtask

    task automatic test_reject;
        logic       pl[3]  = '{1'b1, 1'b0, 1'b0};
        logic [8:0] sel[3] = '{9'h002, 9'h003, 9'h010};
        for (int i = 0; i < 3; i++) begin
            drive_play(pl[i], sel[i]);
            checks++;
            if (play_err !== 1'b1 || state_o !== 3'b001 || p1_hand !== m_h1 || p2_hand !== m_h2) begin
                errors++;
                $display("FAIL reject_%0d: err=%b state=%b hands=%h/%h want 1/001/%h/%h", i, play_err,
                         state_o, p1_hand, p2_hand, m_h1, m_h2);
            end
            tick;
            checks++;
            if (play_err !== 1'b0) begin
                errors++; $display("FAIL reject_pulse_%0d: err=%b want 0", i, play_err);
            end
        end
    endtask

    task automatic test_draw;
        play_round(3, 3);
        checks++;
        if (win !== 4'd1 || lose !== 4'd0 || turn !== 1'b0 || match_result !== 2'b11) begin
            errors++; $display("FAIL draw: win=%0d lose=%0d turn=%b mr=%b", win, lose, turn, match_result);
        end
    endtask

    task automatic test_abort;
        abort = 1'b1; start = 1'b1; play_valid = 1'b1; play_player = 1'b0; play_sel = 9'h100;
        tick;
        abort = 1'b0; start = 1'b0; play_valid = 1'b0; play_sel = 9'd0;
        checks++;
        if (state_o !== 3'b000 || p1_hand !== 9'h1FF || round !== 4'd0 || win !== 4'd0 || play_err !== 1'b0) begin
            errors++;
            $display("FAIL abort: state=%b hand=%h round=%0d win=%0d err=%b", state_o, p1_hand, round, win, play_err);
        end
    endtask

    task automatic test_win_target;
        int c1[5] = '{8, 7, 6, 5, 4};
        int c2[5] = '{4, 3, 2, 1, 0};
        new_game;
        for (int i = 0; i < 5; i++) play_round(c1[i], c2[i]);
        checks++;
        if (game_over !== 1'b1 || game_result !== 2'b01 || round !== 4'd5) begin
            errors++; $display("FAIL win5: over=%b result=%b round=%0d want 1/01/5", game_over, game_result, round);
        end
        new_game;
        checks++;
        if (round !== 4'd0 || p1_hand !== 9'h1FF || p2_hand !== 9'h1FF || state_o !== 3'b001) begin
            errors++; $display("FAIL restart: round=%0d hands=%h/%h state=%b", round, p1_hand, p2_hand, state_o);
        end
    endtask

    task automatic test_full_game;
        int c2[9] = '{1, 0, 3, 2, 5, 4, 7, 6, 8};
        for (int i = 0; i < 9; i++) play_round(i, c2[i]);
        checks++;
        if (state_o !== 3'b101 || game_result !== 2'b11 || win !== 4'd4 || lose !== 4'd4 || round !== 4'd9) begin
            errors++;
            $display("FAIL full9: state=%b result=%b score=%0d-%0d round=%0d", state_o, game_result, win, lose, round);
        end
    endtask

    task automatic test_reset_in_resolve;
        new_game;
        play_round(8, 0);
        drive_play(1'b0, 9'h080);
        drive_play(1'b1, 9'h002);
        checks++;
        if (state_o !== 3'b011) begin
            errors++; $display("FAIL at_resolve: state=%b want 011", state_o);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (state_o !== 3'b000 || round !== 4'd0 || win !== 4'd0 || lose !== 4'd0 || match_result !== 2'b00) begin
            errors++;
            $display("FAIL reset_resolve: state=%b round=%0d win=%0d lose=%0d mr=%b", state_o, round, win, lose, match_result);
        end
        tick;
        reset = 1'b0;
        tick;
        checks++;
        if (state_o !== 3'b000 || round !== 4'd0 || win !== 4'd0) begin
            errors++; $display("FAIL post_reset: state=%b round=%0d win=%0d", state_o, round, win);
        end
    endtask

`ifdef BAW_TURN_TIMEOUT_EN
    task automatic test_timeout;
        int early = 0;
        new_game;
        for (int i = 0; i < 19; i++) begin
            tick;
            if (timeout_fired !== 1'b0 || state_o !== 3'b001) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL timeout_early: %0d early cycles, want 0", early);
        end
        tick;
        checks++;
        if (timeout_fired !== 1'b1 || p1_card !== 4'd0 || p1_hand !== 9'h1FE || state_o !== 3'b010) begin
            errors++;
            $display("FAIL timeout: fired=%b card=%0d hand=%h state=%b want 1/0/1fe/010", timeout_fired,
                     p1_card, p1_hand, state_o);
        end
        tick;
        checks++;
        if (timeout_fired !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse: fired=%b want 0", timeout_fired);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic_round;
        test_reject;
        test_draw;
        test_abort;
        test_win_target;
        test_full_game;
        test_reset_in_resolve;
`ifdef BAW_TURN_TIMEOUT_EN
        test_timeout;
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
